// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide issue controller:
// FSM state encoding, the $rstatus register index and its exception codes.
package multdiv_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } md_state_t;

    localparam logic [4:0]  RSTATUS_REG = 5'd30;

    localparam logic [31:0] EXC_MULT    = 32'd4;
    localparam logic [31:0] EXC_DIV     = 32'd5;
    localparam logic [31:0] EXC_TIMEOUT = 32'd6;

    // $rstatus code for an exception raised by the issued op type
    function automatic logic [31:0] exc_code(input logic op_mult);
        return op_mult ? EXC_MULT : EXC_DIV;
    endfunction

endpackage

// File: rtl/md_wait_counter.sv
// Wait counter for the multdiv handshake: cleared while not waiting,
// counts up while waiting and saturates at MAX_WAIT (never wraps).
module md_wait_counter #(
    parameter int unsigned MIN_WAIT = 2,
    parameter int unsigned MAX_WAIT = 40,
    parameter int unsigned CNT_W    = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic ge_min,
    output logic at_max
);

    localparam logic [CNT_W-1:0] MIN_VAL = CNT_W'(MIN_WAIT);
    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] count;

    // Saturating up-counter with synchronous clear
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + ONE;
        end
    end

    assign ge_min = (count >= MIN_VAL);
    assign at_max = (count == MAX_VAL);

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Processor-side initiator for the iterative multiply/divide unit.
// Captures a MULT/DIV from EX, pulses the start strobe once, stalls the
// pipeline until a qualified result-ready (or timeout), then performs a
// single-cycle register-file writeback; exceptions are reported to $rstatus.
module multdiv_issue_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int unsigned MIN_WAIT = 2,
    parameter int unsigned MAX_WAIT = 40,
    parameter int unsigned CNT_W    = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_is_mult,
    input  logic        ex_is_div,
    input  logic [31:0] ex_opA,
    input  logic [31:0] ex_opB,
    input  logic [4:0]  ex_rd,
    input  logic        flush,
    input  logic [31:0] data_result,
    input  logic        mult_exception,
    input  logic        div_exception,
    input  logic        data_resultRDY,
    output logic [31:0] data_operandA,
    output logic [31:0] data_operandB,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy
);

    md_state_t  state;
    logic       op_mult;
    logic [4:0] rd_q;
    logic       wb_valid_q;

    logic request;
    logic cnt_clear;
    logic cnt_inc;
    logic ge_min;
    logic at_max;
    logic rdy_ok;
    logic op_exc;

    assign request   = ex_is_mult | ex_is_div;
    assign cnt_inc   = (state == ST_WAIT);
    assign cnt_clear = (state != ST_WAIT);
    assign rdy_ok    = data_resultRDY & ge_min;
    // only the flag belonging to the issued op type is meaningful
    assign op_exc    = op_mult ? mult_exception : div_exception;

    md_wait_counter #(
        .MIN_WAIT (MIN_WAIT),
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_wait_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .inc    (cnt_inc),
        .ge_min (ge_min),
        .at_max (at_max)
    );

    // Issue FSM with registered strobe, operand and writeback outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            op_mult       <= 1'b0;
            rd_q          <= '0;
            data_operandA <= '0;
            data_operandB <= '0;
            ctrl_MULT     <= 1'b0;
            ctrl_DIV      <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
        end else begin
            ctrl_MULT  <= 1'b0;
            ctrl_DIV   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (request && !flush) begin
                        // operands stay frozen from here until WB is left
                        data_operandA <= ex_opA;
                        data_operandB <= ex_opB;
                        rd_q          <= ex_rd;
                        op_mult       <= ex_is_mult;
                        ctrl_MULT     <= ex_is_mult;
                        ctrl_DIV      <= ~ex_is_mult;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= flush ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (rdy_ok) begin
                        state      <= ST_WB;
                        wb_valid_q <= op_exc | (rd_q != 5'd0);
                        wb_rd      <= op_exc ? RSTATUS_REG : rd_q;
                        wb_data    <= op_exc ? exc_code(op_mult) : data_result;
                    end else if (at_max) begin
                        state      <= ST_WB;
                        wb_valid_q <= 1'b1;
                        wb_rd      <= RSTATUS_REG;
                        wb_data    <= EXC_TIMEOUT;
                    end
                end
                ST_WB: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // a flush arriving during WB squashes the write in that same cycle
    assign wb_valid = wb_valid_q & ~flush;
    assign stall    = ((state == ST_IDLE) & request & ~flush)
                    | (state == ST_ISSUE)
                    | (state == ST_WAIT);
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Self-checking bench for multdiv_issue_ctrl: directed and randomized
// MULT/DIV transactions checked cycle by cycle against a timeline model.
`timescale 1ns/1ps
module tb_multdiv_issue_ctrl;

    localparam int MIN_WAIT = 2;
    localparam int MAX_WAIT = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_is_mult;
    logic        ex_is_div;
    logic [31:0] ex_opA;
    logic [31:0] ex_opB;
    logic [4:0]  ex_rd;
    logic        flush;
    logic [31:0] data_result;
    logic        mult_exception;
    logic        div_exception;
    logic        data_resultRDY;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;

    multdiv_issue_ctrl #(
        .MIN_WAIT (MIN_WAIT),
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (6)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ex_is_mult     (ex_is_mult),
        .ex_is_div      (ex_is_div),
        .ex_opA         (ex_opA),
        .ex_opB         (ex_opB),
        .ex_rd          (ex_rd),
        .flush          (flush),
        .data_result    (data_result),
        .mult_exception (mult_exception),
        .div_exception  (div_exception),
        .data_resultRDY (data_resultRDY),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .stall          (stall),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cur_op = 0;
    int cur_k  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s op=%0d cyc=%0d got=%0h exp=%0h", tag, cur_op, cur_k, got, exp);
        end
    endtask

    task automatic drive_quiet();
        ex_is_mult     = 1'b0;
        ex_is_div      = 1'b0;
        ex_opA         = $urandom;
        ex_opB         = $urandom;
        ex_rd          = 5'($urandom);
        flush          = 1'b0;
        data_result    = $urandom;
        mult_exception = 1'b0;
        div_exception  = 1'b0;
        data_resultRDY = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".opA"},   data_operandA, 32'd0);
        check_eq({tag, ".opB"},   data_operandB, 32'd0);
        check_eq({tag, ".cmul"},  ctrl_MULT, 1'b0);
        check_eq({tag, ".cdiv"},  ctrl_DIV, 1'b0);
        check_eq({tag, ".stall"}, stall, 1'b0);
        check_eq({tag, ".busy"},  busy, 1'b0);
        check_eq({tag, ".wbv"},   wb_valid, 1'b0);
        check_eq({tag, ".wbrd"},  wb_rd, 5'd0);
        check_eq({tag, ".wbd"},   wb_data, 32'd0);
    endtask

    // One transaction. Cycle k=0 is the accept cycle, k=1 the pulse cycle.
    // RDY is held high from pulse+rs onward. fmode: 0 none, 1 flush in
    // ISSUE, 2 flush in WAIT at counter fcnt, 3 flush during WB.
    task automatic run_op(input logic is_m, input logic is_d,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input int rs, input logic [31:0] res,
                          input logic mexc, input logic dexc,
                          input int fmode, input int fcnt, input logic tail);
        logic        mult, timeout, exc, flushed, wbflush, req;
        int          c_q, c_end, dec, last, fcyc, fc;
        logic        exp_v;
        logic [4:0]  exp_rd;
        logic [31:0] exp_d;

        cur_op++;
        mult    = is_m;
        // earliest counter value at which RDY is both present and qualified
        c_q     = (rs - 1 > MIN_WAIT) ? rs - 1 : MIN_WAIT;
        timeout = (c_q > MAX_WAIT);
        c_end   = timeout ? MAX_WAIT : c_q;
        dec     = 2 + c_end;
        flushed = 1'b0;
        wbflush = (fmode == 3);
        fcyc    = -1;
        if (fmode == 1) begin
            flushed = 1'b1;
            fcyc    = 1;
        end else if (fmode == 2) begin
            fc      = (fcnt > c_end) ? c_end : fcnt;
            flushed = 1'b1;
            fcyc    = 2 + fc;
        end
        last = flushed ? fcyc : dec + 1;

        exc = mult ? mexc : dexc;
        if (timeout) begin
            exp_v = 1'b1; exp_rd = 5'd30; exp_d = 32'd6;
        end else if (exc) begin
            exp_v = 1'b1; exp_rd = 5'd30; exp_d = mult ? 32'd4 : 32'd5;
        end else begin
            exp_v = (rd != 5'd0); exp_rd = rd; exp_d = res;
        end
        if (wbflush) exp_v = 1'b0;

        for (int k = 0; k <= (tail ? last + 1 : last); k++) begin
            @(negedge clock);
            cur_k = k;
            req   = (k <= last);
            ex_is_mult = req ? is_m : 1'b0;
            ex_is_div  = req ? is_d : 1'b0;
            if (k == 0) begin
                ex_opA = a; ex_opB = b; ex_rd = rd;
            end else begin
                ex_opA = $urandom; ex_opB = $urandom; ex_rd = 5'($urandom);
            end
            flush          = (flushed && k == fcyc) || (wbflush && k == dec + 1);
            data_resultRDY = (k >= 1 + rs) && (k <= last);
            data_result    = data_resultRDY ? res : $urandom;
            mult_exception = mexc;
            div_exception  = dexc;
            #1;
            check_eq("ctrl_MULT", ctrl_MULT, (k == 1) && mult);
            check_eq("ctrl_DIV",  ctrl_DIV,  (k == 1) && !mult);
            check_eq("stall",     stall,     flushed ? (k <= fcyc) : (k <= dec));
            check_eq("busy",      busy,      (k >= 1) && (k <= last));
            check_eq("wb_valid",  wb_valid,  (!flushed && k == dec + 1) ? exp_v : 1'b0);
            if (!flushed && k == dec + 1) begin
                check_eq("wb_rd",   wb_rd,   exp_rd);
                check_eq("wb_data", wb_data, exp_d);
            end
            if (k >= 1 && k <= last) begin
                check_eq("opA", data_operandA, a);
                check_eq("opB", data_operandB, b);
            end
        end
    endtask

    initial begin
        int sel, r, fm, fcn;
        logic im, id;
        logic [4:0] rrd;
        int rs;

        reset = 1'b1;
        drive_quiet();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        cur_k = 0;
        check_all_zero("rst");

        // MULT 7x6 -> r3, RDY at pulse+17
        run_op(1, 0, 32'd7, 32'd6, 5'd3, 17, 32'd42, 0, 0, 0, 0, 1);
        // DIV 100/0 with divide-by-zero, stray mult flag ignored
        run_op(0, 1, 32'd100, 32'd0, 5'd9, 10, 32'hdead, 1, 1, 0, 0, 1);
        // DIV ignoring the mult flag -> normal writeback
        run_op(0, 1, 32'd100, 32'd7, 5'd9, 8, 32'd14, 1, 0, 0, 0, 1);
        // MULT overflow
        run_op(1, 0, 32'hffff_ffff, 32'd3, 5'd4, 6, 32'h1234, 1, 0, 0, 0, 1);
        // stale RDY from the pulse cycle onward
        run_op(1, 0, 32'd3, 32'd5, 5'd7, 0, 32'd15, 0, 0, 0, 0, 1);
        // flush in WAIT at counter 10, RDY arriving later, then new MULT back to back
        run_op(1, 0, 32'd2, 32'd2, 5'd8, 15, 32'd4, 0, 0, 2, 10, 0);
        run_op(1, 0, 32'd9, 32'd9, 5'd8, 5, 32'd81, 0, 0, 0, 0, 1);
        // no RDY ever -> timeout
        run_op(0, 1, 32'd50, 32'd5, 5'd2, 1000, 32'd10, 0, 0, 0, 0, 1);
        // RDY qualifies exactly at the saturation count, and one cycle too late
        run_op(1, 0, 32'd1, 32'd1, 5'd5, 41, 32'd1, 0, 0, 0, 0, 1);
        run_op(1, 0, 32'd1, 32'd1, 5'd5, 42, 32'd1, 0, 0, 0, 0, 1);
        // both op flags high, rd=0 -> MULT only, no write
        run_op(1, 1, 32'd11, 32'd12, 5'd0, 4, 32'd132, 0, 0, 0, 0, 1);
        // flush in ISSUE, flush during WB, flush on the same cycle as qualified RDY
        run_op(0, 1, 32'd8, 32'd2, 5'd6, 3, 32'd4, 0, 0, 1, 0, 1);
        run_op(1, 0, 32'd8, 32'd2, 5'd6, 3, 32'd16, 0, 0, 3, 0, 1);
        run_op(1, 0, 32'd8, 32'd2, 5'd6, 5, 32'd16, 0, 0, 2, 4, 1);

        // flush while a request is visible in IDLE blocks acceptance
        @(negedge clock);
        cur_k = -1;
        ex_is_mult = 1'b1; ex_is_div = 1'b0; flush = 1'b1;
        #1;
        check_eq("idle_flush.stall", stall, 1'b0);
        run_op(1, 0, 32'd6, 32'd6, 5'd1, 3, 32'd36, 0, 0, 0, 0, 1);

        // reset in the middle of WAIT abandons the op silently
        cur_op++;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clock);
            cur_k = k;
            drive_quiet();
            ex_is_mult = 1'b1;
            if (k == 0) begin
                ex_opA = 32'd9; ex_opB = 32'd9; ex_rd = 5'd4;
            end
            reset = (k == 7);
        end
        @(negedge clock);
        cur_k = 8;
        reset = 1'b0;
        drive_quiet();
        #1;
        check_all_zero("midrst");
        for (int k = 9; k < 55; k++) begin
            @(negedge clock);
            cur_k = k;
            drive_quiet();
            data_resultRDY = 1'b1;
            #1;
            check_eq("midrst.wbv",  wb_valid, 1'b0);
            check_eq("midrst.busy", busy, 1'b0);
        end

        // randomized transactions
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 3);
            im  = (sel != 1);
            id  = (sel == 1) || (sel == 2);
            rrd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            r   = $urandom_range(0, 9);
            rs  = (r == 0) ? 1000 : (r == 1) ? 41 : (r == 2) ? 42 : $urandom_range(0, 20);
            fm  = $urandom_range(0, 7);
            fcn = $urandom_range(0, 42);
            run_op(im, id, $urandom, $urandom, rrd, rs, $urandom,
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                   (fm == 0) ? 1 : (fm == 1) ? 2 : (fm == 2) ? 3 : 0,
                   fcn, 1'($urandom_range(0, 1)));
        end

        @(negedge clock);
        drive_quiet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
